// File: rtl/traffic_button_debouncer_if.sv
// Button debouncer signal bundle: raw input and ack towards the debouncer,
// debounced level/pulse/request/count and FSM debug state back.
interface traffic_button_debouncer_if;
   logic       in_sync;
   logic       ack;
   logic       level;
   logic       press_pulse;
   logic       request;
   logic [7:0] press_count;
   logic [1:0] dbg_state;

   modport master (
      output in_sync, ack,
      input  level, press_pulse, request, press_count, dbg_state
   );

   modport slave (
      input  in_sync, ack,
      output level, press_pulse, request, press_count, dbg_state
   );
endinterface

// File: rtl/traffic_button_debouncer.sv
// Debounces a synchronized button level into a clean level, a press pulse,
// a sticky request and a press counter (enabled by TRAFFIC_BTN_PRESS_COUNT_EN).
module traffic_button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   traffic_button_debouncer_if.slave   btn
);

   typedef enum logic [1:0] {
      S_LOW  = 2'd0,
      S_RISE = 2'd1,
      S_HIGH = 2'd2,
      S_FALL = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             pulse_q, pulse_d;
   logic             request_q, request_d;
   logic             accept_press;
   logic             accept_release;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_LOW;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_LOW: begin
            if (btn.in_sync) begin
               state_d = S_RISE;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d   = '0;
            end
         end
         S_RISE: begin
            if (!btn.in_sync) begin
               state_d = S_LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_HIGH;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         S_HIGH: begin
            if (!btn.in_sync) begin
               state_d = S_FALL;
               cnt_d   = CNT_ONE;
            end
         end
         S_FALL: begin
            if (btn.in_sync) begin
               state_d = S_HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_LOW;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = S_LOW;
            cnt_d   = '0;
         end
      endcase
   end

   assign accept_press   = (state_q == S_RISE) && btn.in_sync  && (cnt_q == CNT_LAST);
   assign accept_release = (state_q == S_FALL) && !btn.in_sync && (cnt_q == CNT_LAST);

   // A new press wins over a coincident ack, which refers to the earlier press.
   always_comb begin
      level_d   = level_q;
      if (accept_press)   level_d = 1'b1;
      if (accept_release) level_d = 1'b0;
      pulse_d   = accept_press;
      request_d = accept_press | (request_q & ~btn.ack);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         level_q   <= 1'b0;
         pulse_q   <= 1'b0;
         request_q <= 1'b0;
      end else begin
         level_q   <= level_d;
         pulse_q   <= pulse_d;
         request_q <= request_d;
      end
   end

`ifdef TRAFFIC_BTN_PRESS_COUNT_EN
   logic [7:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (accept_press && (count_q != 8'hFF)) count_d = count_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) count_q <= 8'd0;
      else       count_q <= count_d;
   end

   assign btn.press_count = count_q;
`else
   assign btn.press_count = 8'd0;
`endif

   assign btn.level       = level_q;
   assign btn.press_pulse = pulse_q;
   assign btn.request     = request_q;
   assign btn.dbg_state   = state_q;

endmodule

// File: tb/tb_traffic_button_debouncer.sv
// Directed bench for traffic_button_debouncer with DEBOUNCE_CYCLES = 4.
module tb_traffic_button_debouncer;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   traffic_button_debouncer_if btn ();

   traffic_button_debouncer #(
      .DEBOUNCE_CYCLES (4),
      .CNT_W           (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .btn   (btn)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One rising edge, then settle; inputs change and outputs are sampled here.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] exp_count(input int n);
`ifdef TRAFFIC_BTN_PRESS_COUNT_EN
      return (n > 255) ? 8'd255 : 8'(n);
`else
      return 8'd0 + 8'(n * 0);
`endif
   endfunction

   initial begin
      checks      = 0;
      errors      = 0;
      reset       = 1'b1;
      btn.in_sync = 1'b0;
      btn.ack     = 1'b0;
      steps(2);
      reset = 1'b0;
      step();
      chk("reset_level",   {7'd0, btn.level},       8'd0);
      chk("reset_pulse",   {7'd0, btn.press_pulse}, 8'd0);
      chk("reset_request", {7'd0, btn.request},     8'd0);
      chk("reset_count",   btn.press_count,         exp_count(0));
      chk("reset_state",   {6'd0, btn.dbg_state},   8'd0);

      // Clean press: accepted on the 4th edge sampling 1.
      btn.in_sync = 1'b1;
      steps(3);
      chk("press_e3_level", {7'd0, btn.level},     8'd0);
      chk("press_e3_state", {6'd0, btn.dbg_state}, 8'd1);
      step();
      chk("press_e4_level",   {7'd0, btn.level},       8'd1);
      chk("press_e4_pulse",   {7'd0, btn.press_pulse}, 8'd1);
      chk("press_e4_request", {7'd0, btn.request},     8'd1);
      chk("press_e4_count",   btn.press_count,         exp_count(1));
      step();
      chk("press_pulse_once", {7'd0, btn.press_pulse}, 8'd0);
      chk("press_hold_level", {7'd0, btn.level},       8'd1);

      // Release: symmetric latency, no pulse, request stays pending.
      btn.in_sync = 1'b0;
      steps(3);
      chk("rel_e3_level", {7'd0, btn.level}, 8'd1);
      step();
      chk("rel_e4_level",   {7'd0, btn.level},       8'd0);
      chk("rel_e4_pulse",   {7'd0, btn.press_pulse}, 8'd0);
      chk("rel_e4_request", {7'd0, btn.request},     8'd1);

      // Ack clears request; a second ack changes nothing.
      btn.ack = 1'b1;
      step();
      btn.ack = 1'b0;
      chk("ack_clears", {7'd0, btn.request}, 8'd0);
      btn.ack = 1'b1;
      step();
      btn.ack = 1'b0;
      chk("ack_again",       {7'd0, btn.request}, 8'd0);
      chk("ack_again_count", btn.press_count,     exp_count(1));

      // Bounce 1,1,0,1,1,1,0 never qualifies.
      begin
         logic [6:0] bounce;
         bounce = 7'b1101110;
         for (int i = 6; i >= 0; i--) begin
            btn.in_sync = bounce[i];
            step();
            chk("bounce_level", {7'd0, btn.level},       8'd0);
            chk("bounce_pulse", {7'd0, btn.press_pulse}, 8'd0);
         end
      end
      chk("bounce_request", {7'd0, btn.request},     8'd0);
      chk("bounce_state",   {6'd0, btn.dbg_state},   8'd0);
      chk("bounce_count",   btn.press_count,         exp_count(1));

      // Second press leaves request pending, then a third press coincides with ack.
      btn.in_sync = 1'b1;
      steps(4);
      chk("p2_request", {7'd0, btn.request}, 8'd1);
      chk("p2_count",   btn.press_count,     exp_count(2));
      btn.in_sync = 1'b0;
      steps(4);
      chk("p2_rel_level", {7'd0, btn.level}, 8'd0);
      btn.in_sync = 1'b1;
      steps(3);
      btn.ack = 1'b1;
      step();
      btn.ack = 1'b0;
      chk("coinc_request", {7'd0, btn.request},     8'd1);
      chk("coinc_pulse",   {7'd0, btn.press_pulse}, 8'd1);
      chk("coinc_count",   btn.press_count,         exp_count(3));
      btn.in_sync = 1'b0;
      steps(4);

      // Reset during S_RISE at cnt=2 discards progress and clears request.
      btn.in_sync = 1'b1;
      steps(2);
      chk("mid_state_rise", {6'd0, btn.dbg_state}, 8'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mid_rst_level",   {7'd0, btn.level},       8'd0);
      chk("mid_rst_pulse",   {7'd0, btn.press_pulse}, 8'd0);
      chk("mid_rst_request", {7'd0, btn.request},     8'd0);
      chk("mid_rst_count",   btn.press_count,         exp_count(0));
      chk("mid_rst_state",   {6'd0, btn.dbg_state},   8'd0);
      steps(3);
      chk("post_rst_e3_level", {7'd0, btn.level}, 8'd0);
      step();
      chk("post_rst_e4_level", {7'd0, btn.level}, 8'd1);
      chk("post_rst_e4_count", btn.press_count,   exp_count(1));
      btn.in_sync = 1'b0;
      steps(4);

      // 260 clean presses saturate the counter.
      for (int p = 0; p < 260; p++) begin
         btn.in_sync = 1'b1;
         steps(4);
         btn.in_sync = 1'b0;
         steps(4);
      end
      chk("sat_count", btn.press_count, exp_count(261));
      chk("sat_level", {7'd0, btn.level}, 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
